// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind a valid/ready handshake.
// One access in flight at a time, answered after LATENCY wait cycles.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  to_resp;
    logic                  cur_we;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_be;
    logic [31:0]           cur_hi;
    logic                  cur_err;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic                  mem_we;

    assign req_ready  = (state_q == IDLE) & reset;
    assign accept     = req_valid & req_ready;
    assign resp_valid = rvalid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign stall      = req_valid & ~rvalid_q;

    // With zero latency the access completes straight from the live inputs.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state_q == IDLE) ? req_be    : be_q;
    assign cur_hi    = cur_addr >> (DEPTH_LOG2 + 2);
    assign cur_err   = (cur_addr[1:0] != 2'b00) | (cur_hi != 32'd0);
    assign cur_idx   = cur_addr[DEPTH_LOG2+1:2];

    assign to_resp = (state_q == IDLE && accept && LAT == 4'd0)
                   | (state_q == WAIT && cnt_q <= 4'd1);
    assign mem_we  = reset & to_resp & cur_we & ~cur_err;

    // Next-state, request capture and response formation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (LAT == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (to_resp) begin
            rvalid_d = 1'b1;
            err_d    = cur_err;
            if (!cur_err && !cur_we) begin
                rdata_d = mem[cur_idx];
            end
        end
    end

    // Control FSM and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Storage array keeps its contents across reset; byte-lane writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed accesses on a LATENCY=2 and a
// LATENCY=0 instance, checked against a word-array reference model.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        req_ready [2];
    logic        resp_valid[2];
    logic [31:0] resp_rdata[2];
    logic        resp_err  [2];
    logic        stall     [2];

    logic [31:0] model [2][64];
    int          passed;
    int          total;
    logic [31:0] got;

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .stall(stall[0])
    );

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .stall(stall[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        int w;
        r = $urandom_range(0, 9);
        w = $urandom_range(0, 63);
        if (r == 0) return $urandom;
        if (r == 1) return 32'(w * 4 + $urandom_range(1, 3));
        return 32'(w * 4);
    endfunction

    // One full transaction with cycle-exact handshake checks.
    task automatic do_req(input int d, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd);
        int          lat;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        lat     = (d == 0) ? 2 : 0;
        exp_err = (addr % 4 != 0) || (addr >= 32'd256);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            idx = int'(addr / 4);
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[d][idx][8*i +: 8] = wdata[8*i +: 8];
            end else begin
                exp_rd = model[d][idx];
            end
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        #1;
        chk1("req_ready", req_ready[d], 1'b1);
        chk1("req_stall", stall[d], 1'b1);
        tick;
        for (int k = 0; k < lat; k++) begin
            chk1("wait_rvalid", resp_valid[d], 1'b0);
            chk1("wait_stall", stall[d], 1'b1);
            chk1("wait_ready", req_ready[d], 1'b0);
            req_we[d]    = 1'($urandom);
            req_addr[d]  = $urandom;
            req_wdata[d] = $urandom;
            req_be[d]    = 4'($urandom);
            tick;
        end
        chk1("resp_rvalid", resp_valid[d], 1'b1);
        chk1("resp_err", resp_err[d], exp_err);
        chk32("resp_rdata", resp_rdata[d], exp_rd);
        chk1("resp_stall", stall[d], 1'b0);
        chk1("resp_ready", req_ready[d], 1'b0);
        rd = resp_rdata[d];
        req_valid[d] = 1'b0;
        tick;
        chk1("idle_rvalid", resp_valid[d], 1'b0);
        chk32("idle_rdata", resp_rdata[d], 32'd0);
        chk1("idle_err", resp_err[d], 1'b0);
        chk1("idle_ready", req_ready[d], 1'b1);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            req_be[d]    = 4'd0;
        end
        req_valid[0] = 1'b1;

        // Reset state, with a request pending on the first instance.
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1("rst_ready", req_ready[d], 1'b0);
            chk1("rst_rvalid", resp_valid[d], 1'b0);
            chk32("rst_rdata", resp_rdata[d], 32'd0);
            chk1("rst_err", resp_err[d], 1'b0);
            chk1("rst_stall", stall[d], req_valid[d]);
        end
        tick;
        tick;
        tick;
        chk1("rst_no_resp", resp_valid[0], 1'b0);
        req_valid[0] = 1'b0;
        reset = 1'b1;

        // Fill both memories so every later load has a known answer.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                do_req(d, 1'b1, 32'(w * 4), $urandom, 4'hF, got);

        // Full store then load.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, got);
        chk32("load_deadbeef", got, 32'hDEADBEEF);

        // Partial lane store.
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, got);
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, got);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, got);
        chk32("load_partial", got, 32'hAA22CC44);

        // Empty byte-enable store completes without writing.
        do_req(0, 1'b1, 32'h20, 32'h55555555, 4'b0000, got);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, got);
        chk32("load_be0", got, 32'hAA22CC44);

        // Error accesses.
        do_req(0, 1'b0, 32'h2, 32'h0, 4'h0, got);
        do_req(0, 1'b0, 32'h100, 32'h0, 4'h0, got);
        do_req(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, got);
        do_req(1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, got);
        do_req(1, 1'b0, 32'h3, 32'h0, 4'h0, got);

        // Reset in the middle of a wait aborts a store.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = ~model[0][12];
        req_be[0]    = 4'hF;
        #1;
        chk1("abort_ready", req_ready[0], 1'b1);
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk1("abort_rvalid", resp_valid[0], 1'b0);
        chk32("abort_rdata", resp_rdata[0], 32'd0);
        chk1("abort_err", resp_err[0], 1'b0);
        chk1("abort_ready0", req_ready[0], 1'b0);
        chk1("abort_stall", stall[0], 1'b1);
        tick;
        chk1("abort_no_resp", resp_valid[0], 1'b0);
        req_valid[0] = 1'b0;
        #1;
        chk1("abort_stall0", stall[0], 1'b0);
        @(negedge clk);
        reset = 1'b1;
        do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, got);

        // Back-to-back loads with request held high, zero latency.
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int w;
            w = $urandom_range(0, 63);
            req_addr[1] = 32'(w * 4);
            #1;
            chk1("b2b_ready1", req_ready[1], 1'b1);
            chk1("b2b_rvalid0", resp_valid[1], 1'b0);
            chk1("b2b_stall1", stall[1], 1'b1);
            tick;
            chk1("b2b_ready0", req_ready[1], 1'b0);
            chk1("b2b_rvalid1", resp_valid[1], 1'b1);
            chk1("b2b_stall0", stall[1], 1'b0);
            chk32("b2b_rdata", resp_rdata[1], model[1][w]);
            tick;
        end
        req_valid[1] = 1'b0;
        tick;

        // Random mixed traffic.
        for (int i = 0; i < 60; i++)
            do_req(0, 1'($urandom), rand_addr(), $urandom, 4'($urandom), got);
        for (int i = 0; i < 40; i++)
            do_req(1, 1'($urandom), rand_addr(), $urandom, 4'($urandom), got);

        // Final sweep of every word.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                do_req(d, 1'b0, 32'(w * 4), 32'h0, 4'h0, got);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
